// File: rtl/div_by4_pkg.sv
// Shared definitions for the serial divisibility detector.
// Remainder states for DIVISOR=4 and a scalar next-remainder helper.
package div_by4_pkg;

    localparam int unsigned DIV_DEFAULT = 4;

    // Remainder states for the modulo-4 machine: Sn holds remainder n.
    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } state_e;

    // One serial step: (2*rem + din) mod divisor, assuming rem < divisor.
    function automatic int unsigned rem_next(
        input int unsigned rem,
        input logic        din,
        input int unsigned divisor
    );
        int unsigned t;
        t = 2 * rem + int'(din);
        if (t >= divisor) begin
            t = t - divisor;
        end
        return t;
    endfunction

endpackage

// File: rtl/div_by4_step.sv
// Combinational next-remainder logic for the serial divisibility detector.
// Ports: rem_i current remainder, din_i serial bit, rem_d_o next remainder.
module div_by4_step
    import div_by4_pkg::*;
#(
    parameter int unsigned DIVISOR = DIV_DEFAULT,
    parameter int unsigned REM_W   = $clog2(DIVISOR)
) (
    input  logic [REM_W-1:0] rem_i,
    input  logic             din_i,
    output logic [REM_W-1:0] rem_d_o
);

    generate
        if (DIVISOR == 4 && REM_W == 2) begin : g_fsm
            state_e cur;
            state_e nxt;

            assign cur = state_e'(rem_i);

            // Shifting in a bit drops the old MSB, so S0/S2 and S1/S3
            // lead to the same successors.
            always_comb begin
                nxt = S0;
                unique case (cur)
                    S0, S2:  nxt = din_i ? S1 : S0;
                    S1, S3:  nxt = din_i ? S3 : S2;
                    default: nxt = S0;
                endcase
            end

            assign rem_d_o = nxt;
        end else begin : g_arith
            localparam logic [REM_W:0] DIV_C = (REM_W + 1)'(DIVISOR);

            logic [REM_W:0] sum;

            // 2*rem + din is below 2*DIVISOR, so one conditional
            // subtraction is enough to reduce it.
            always_comb begin
                sum     = {rem_i, din_i};
                rem_d_o = sum[REM_W-1:0];
                if ({1'b0, rem_i} >= DIV_C) begin
                    rem_d_o = '0;
                end else if (sum >= DIV_C) begin
                    rem_d_o = REM_W'(sum - DIV_C);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/div_by4.sv
// Serial divisibility detector: tracks the MSB-first stream value mod DIVISOR.
// Ports: clk, rstn (sync active-high), din, detect_divby4 (rem==0), rem.
module div_by4
    import div_by4_pkg::*;
#(
    parameter int unsigned DIVISOR = DIV_DEFAULT,
    parameter int unsigned REM_W   = $clog2(DIVISOR)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             din,
    output logic             detect_divby4,
    output logic [REM_W-1:0] rem
);

    logic [REM_W-1:0] rem_q;
    logic [REM_W-1:0] rem_d;

    div_by4_step #(
        .DIVISOR (DIVISOR),
        .REM_W   (REM_W)
    ) u_step (
        .rem_i   (rem_q),
        .din_i   (din),
        .rem_d_o (rem_d)
    );

    // rstn is active-high despite its name; it wins over din.
    always_ff @(posedge clk) begin
        if (rstn) begin
            rem_q <= '0;
        end else begin
            rem_q <= rem_d;
        end
    end

    assign detect_divby4 = (rem_q == '0);
    assign rem           = rem_q;

endmodule

// File: tb/tb_div_by4.sv
// Self-checking bench for div_by4 at DIVISOR=4 and DIVISOR=3.
// Both instances share clock, reset and din; models use plain modulo math.
module tb_div_by4;
    import div_by4_pkg::*;

    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic       din = 1'b0;
    logic       det4;
    logic       det3;
    logic [1:0] rem4;
    logic [1:0] rem3;

    int n_chk = 0;
    int n_fail = 0;
    int m4 = 0;
    int m3 = 0;

    always #5 clk = ~clk;

    div_by4 #(.DIVISOR(4)) u_dut4 (
        .clk           (clk),
        .rstn          (rstn),
        .din           (din),
        .detect_divby4 (det4),
        .rem           (rem4)
    );

    div_by4 #(.DIVISOR(3)) u_dut3 (
        .clk           (clk),
        .rstn          (rstn),
        .din           (din),
        .detect_divby4 (det3),
        .rem           (rem3)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle, advance the models, compare both DUTs after the edge.
    task automatic step(input logic r, input logic d);
        rstn = r;
        din  = d;
        @(posedge clk);
        #1;
        if (r) begin
            m4 = 0;
            m3 = 0;
        end else begin
            m4 = (m4 * 2 + int'(d)) % 4;
            m3 = (m3 * 2 + int'(d)) % 3;
        end
        chk("rem4", int'(rem4), m4);
        chk("det4", int'(det4), int'(m4 == 0));
        chk("rem3", int'(rem3), m3);
        chk("det3", int'(det3), int'(m3 == 0));
    endtask

    initial begin : main
        int seq1[5];
        int exp1[5];
        int exp1d[5];
        int exp2[4];
        int seq5[3];
        int exp5[3];
        int exp5d[3];
        int prev;
        logic b;
        logic r;

        seq1  = '{0, 0, 1, 0, 0};
        exp1  = '{0, 0, 1, 2, 0};
        exp1d = '{1, 1, 0, 0, 1};
        exp2  = '{1, 3, 3, 3};
        seq5  = '{1, 1, 0};
        exp5  = '{1, 0, 0};
        exp5d = '{0, 1, 1};

        // Reset state: empty stream is value 0.
        step(1'b1, 1'b1);
        chk("rst_rem4", int'(rem4), 0);
        chk("rst_det4", int'(det4), 1);

        // Directed pattern 0,0,1,0,0.
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'(seq1[i]));
            chk("t1_rem4", int'(rem4), exp1[i]);
            chk("t1_det4", int'(det4), exp1d[i]);
        end

        // 1,1,1,1 then 0,0.
        step(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1);
            chk("t2_rem4", int'(rem4), exp2[i]);
            chk("t2_det4", int'(det4), 0);
        end
        step(1'b0, 1'b0);
        chk("t2_rem4_a", int'(rem4), 2);
        step(1'b0, 1'b0);
        chk("t2_rem4_b", int'(rem4), 0);
        chk("t2_det4_b", int'(det4), 1);

        // Mid-stream reset with rem=3 and din=1.
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        chk("t3_pre", int'(rem4), 3);
        step(1'b1, 1'b1);
        chk("t3_rem4", int'(rem4), 0);
        chk("t3_det4", int'(det4), 1);

        // DIVISOR=3 on 1,1,0 (value 6).
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'(seq5[i]));
            chk("t5_rem3", int'(rem3), exp5[i]);
            chk("t5_det3", int'(det3), exp5d[i]);
        end

        // Reset held for 3 cycles with din toggling.
        step(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'(i % 2 == 0));
            chk("t6_rem4", int'(rem4), 0);
            chk("t6_det4", int'(det4), 1);
            chk("t6_rem3", int'(rem3), 0);
        end

        // Random stream, occasional resets; package helper cross-checked too.
        for (int i = 0; i < 1000; i++) begin
            b    = 1'($urandom_range(0, 1));
            r    = ($urandom_range(0, 63) == 0);
            prev = m4;
            step(r, b);
            if (!r) begin
                chk("pkg_fn4", int'(rem_next(prev, b, 4)), m4);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
